spike_row_encoder: RTL and testbench

- FIFO producer for the event path. Takes one row of output spikes at a time as a bitmap plus row index, and serialises every set bit into a packed (x,y) coordinate write on the event FIFO.
- Sits upstream of the FIFO that capture_event drains. It is the writer end of the FIFO protocol that capture_event reads.
- Closes the loop, so layer spikes can be re-injected as events for the next convolution layer.

---
 rtl/spike_row_encoder_pkg.sv | 24 ++
 rtl/spike_row_encoder_ffs.sv | 23 ++
 rtl/spike_row_encoder.sv | 122 ++++++++++++
 tb/tb_spike_row_encoder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_row_encoder_pkg.sv
// Shared event-path types: coordinate bundle, packing, encoder states.
// Packing {x,y} matches the unpack used by capture_event.
package spike_row_encoder_pkg;

  localparam int DEFAULT_COORD_BITS = 8;
  localparam int DEFAULT_IMG_WIDTH  = 16;
  localparam int DEFAULT_IMG_HEIGHT = 16;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0] x;
    logic [DEFAULT_COORD_BITS-1:0] y;
  } vec2_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } spike_enc_state_t;

  function automatic logic [2*DEFAULT_COORD_BITS-1:0]
    pack_coordinates(input vec2_t v);
    return {v.x, v.y};
  endfunction

endpackage

// File: rtl/spike_row_encoder_ffs.sv
// Combinational lowest-set-bit encoder.
// Scans from MSB down so the last hit wins, leaving the lowest index.
module find_first_set #(
  parameter int WIDTH = 16,
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IW-1:0]    o_index,
  output logic             o_found
);

  always_comb begin
    o_index = '0;
    o_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = IW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_row_encoder.sv
// Serialises a row spike bitmap into packed {x,y} FIFO writes,
// lowest x first, one per cycle, stalling on fifo_full or !enable.
module spike_row_encoder
  import spike_row_encoder_pkg::*;
#(
  parameter int COORD_BITS = DEFAULT_COORD_BITS,
  parameter int DATA_WIDTH = 2 * COORD_BITS,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  active,
  output logic                  ready,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [COORD_BITS-1:0] row_y,
  input  logic [IMG_WIDTH-1:0]  row_spikes,
  output logic                  fifo_write_en,
  output logic [DATA_WIDTH-1:0] fifo_write_data,
  input  logic                  fifo_full,
  output logic [COUNT_BITS-1:0] event_count,
  output logic                  row_error
);

  localparam int IW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  if (IMG_WIDTH > 2**COORD_BITS) begin : g_bad_width
    $error("IMG_WIDTH exceeds the x coordinate range");
  end
  if (DATA_WIDTH != 2 * COORD_BITS) begin : g_bad_data
    $error("DATA_WIDTH must equal 2*COORD_BITS");
  end

  spike_enc_state_t      r_state, w_state_n;
  logic [IMG_WIDTH-1:0]  r_mask, w_mask_n;
  logic [COORD_BITS-1:0] r_y, w_y_n;
  logic                  r_wen, w_wen_n;
  logic [DATA_WIDTH-1:0] r_data, w_data_n;
  logic [COUNT_BITS-1:0] r_cnt, w_cnt_n;
  logic                  r_err, w_err_n;

  logic [IW-1:0]         w_idx;
  logic                  w_found;
  logic                  w_idle_en;
  logic                  w_accept;
  logic [IMG_WIDTH-1:0]  w_onehot;

  find_first_set #(.WIDTH(IMG_WIDTH)) u_ffs (
    .i_vec   (r_mask),
    .o_index (w_idx),
    .o_found (w_found)
  );

  assign w_idle_en = (r_state == IDLE) && enable;
  assign w_accept  = row_valid && w_idle_en;
  assign w_onehot  = IMG_WIDTH'(1) << w_idx;

  always_comb begin
    w_state_n = r_state;
    w_mask_n  = r_mask;
    w_y_n     = r_y;
    w_wen_n   = 1'b0;
    w_data_n  = r_data;
    w_cnt_n   = r_cnt;
    w_err_n   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (32'(row_y) >= 32'(IMG_HEIGHT)) begin
            w_err_n = 1'b1;
          end else if (row_spikes != '0) begin
            w_mask_n  = row_spikes;
            w_y_n     = row_y;
            w_state_n = SCAN;
          end
        end
      end
      SCAN: begin
        if (enable && !fifo_full && w_found) begin
          w_wen_n  = 1'b1;
          w_data_n = DATA_WIDTH'({COORD_BITS'(w_idx), r_y});
          w_mask_n = r_mask & ~w_onehot;
          w_cnt_n  = r_cnt + COUNT_BITS'(1);
          if (w_mask_n == '0) w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_y     <= '0;
      r_wen   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_mask  <= w_mask_n;
      r_y     <= w_y_n;
      r_wen   <= w_wen_n;
      r_data  <= w_data_n;
      r_cnt   <= w_cnt_n;
      r_err   <= w_err_n;
    end
  end

  assign active          = (r_state == SCAN);
  assign ready           = w_idle_en;
  assign row_ready       = w_idle_en;
  assign fifo_write_en   = r_wen;
  assign fifo_write_data = r_data;
  assign event_count     = r_cnt;
  assign row_error       = r_err;

endmodule

// File: tb/tb_spike_row_encoder.sv
// Directed bench for spike_row_encoder with an 8-deep FIFO model.
// The FIFO reports full counting a write currently on its input.
module tb_spike_row_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        active;
  logic        ready;
  logic        row_valid;
  logic        row_ready;
  logic [7:0]  row_y;
  logic [15:0] row_spikes;
  logic        fifo_write_en;
  logic [15:0] fifo_write_data;
  logic        fifo_full;
  logic [15:0] event_count;
  logic        row_error;

  int          n_chk = 0;
  int          n_err = 0;
  logic        cons_en = 1'b1;
  int          fcnt = 0;
  logic [15:0] wlog[$];

  spike_row_encoder dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .active          (active),
    .ready           (ready),
    .row_valid       (row_valid),
    .row_ready       (row_ready),
    .row_y           (row_y),
    .row_spikes      (row_spikes),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .fifo_full       (fifo_full),
    .event_count     (event_count),
    .row_error       (row_error)
  );

  always #5 clk = ~clk;

  assign fifo_full = (fcnt + int'(fifo_write_en)) >= 8;

  always @(posedge clk) begin
    if (fifo_write_en) wlog.push_back(fifo_write_data);
    fcnt <= fcnt + int'(fifo_write_en)
                 - int'(cons_en && fcnt != 0);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [7:0] y,
                          input logic [15:0] s);
    row_valid  = 1'b1;
    row_y      = y;
    row_spikes = s;
    check("row_ready_pre", {31'd0, row_ready}, 32'd1);
    tick();
    row_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((active || fifo_write_en) && n < max) begin
      tick();
      n++;
    end
    check(tag, {31'd0, n < max}, 32'd1);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (fcnt != 0 && n < max) begin
      tick();
      n++;
    end
    check("drain", {31'd0, n < max}, 32'd1);
  endtask

  logic [15:0] exp1 [3] = '{16'h0003, 16'h0403, 16'h0F03};
  logic [15:0] exp6 [4] = '{16'h0007, 16'h0107, 16'h0807, 16'h0907};

  initial begin
    logic [15:0] seen;
    logic        ybad;
    reset      = 1'b1;
    enable     = 1'b1;
    row_valid  = 1'b0;
    row_y      = '0;
    row_spikes = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_wen", {31'd0, fifo_write_en}, 32'd0);
    check("rst_count", {16'd0, event_count}, 32'd0);
    check("rst_err", {31'd0, row_error}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_row_ready", {31'd0, row_ready}, 32'd1);

    // row y=3, bits 0,4,15
    wlog.delete();
    send_row(8'd3, 16'h8011);
    check("t1_active", {31'd0, active}, 32'd1);
    check("t1_wen0", {31'd0, fifo_write_en}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_wen", {31'd0, fifo_write_en}, 32'd1);
      check("t1_data", {16'd0, fifo_write_data}, {16'd0, exp1[k]});
    end
    check("t1_count", {16'd0, event_count}, 32'd3);
    check("t1_ready_back", {31'd0, row_ready}, 32'd1);
    tick();
    check("t1_wen_end", {31'd0, fifo_write_en}, 32'd0);
    check("t1_nlog", wlog.size(), 32'd3);

    // empty row
    wlog.delete();
    send_row(8'd5, 16'h0000);
    check("t2_active", {31'd0, active}, 32'd0);
    check("t2_ready", {31'd0, row_ready}, 32'd1);
    tick();
    check("t2_wen", {31'd0, fifo_write_en}, 32'd0);
    check("t2_count", {16'd0, event_count}, 32'd3);
    check("t2_nlog", wlog.size(), 32'd0);

    // out-of-range row
    wlog.delete();
    send_row(8'd20, 16'h0101);
    check("t3_err_hi", {31'd0, row_error}, 32'd1);
    check("t3_active", {31'd0, active}, 32'd0);
    tick();
    check("t3_err_lo", {31'd0, row_error}, 32'd0);
    tick();
    check("t3_count", {16'd0, event_count}, 32'd3);
    check("t3_nlog", wlog.size(), 32'd0);

    // full row against a stalled consumer
    wait_drain(20);
    wlog.delete();
    cons_en = 1'b0;
    send_row(8'd1, 16'hFFFF);
    for (int k = 0; k < 12; k++) tick();
    check("t4_nlog_stall", wlog.size(), 32'd8);
    check("t4_wen_stall", {31'd0, fifo_write_en}, 32'd0);
    check("t4_fcnt", fcnt, 32'd8);
    check("t4_active", {31'd0, active}, 32'd1);
    cons_en = 1'b1;
    wait_idle("t4_timeout", 60);
    check("t4_nlog", wlog.size(), 32'd16);
    seen = '0;
    ybad = 1'b0;
    foreach (wlog[i]) begin
      seen[wlog[i][11:8]] = 1'b1;
      if (wlog[i][7:0] != 8'd1 || wlog[i][15:12] != 4'd0) ybad = 1'b1;
    end
    check("t4_xset", {16'd0, seen}, 32'h0000FFFF);
    check("t4_coord", {31'd0, ybad}, 32'd0);
    check("t4_count", {16'd0, event_count}, 32'd19);

    // reset mid-scan
    wait_drain(20);
    wlog.delete();
    send_row(8'd2, 16'h00F0);
    tick();
    check("t5_d0", {16'd0, fifo_write_data}, 32'h0402);
    tick();
    check("t5_d1", {16'd0, fifo_write_data}, 32'h0502);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_wen", {31'd0, fifo_write_en}, 32'd0);
    check("t5_count", {16'd0, event_count}, 32'd0);
    check("t5_ready", {31'd0, row_ready}, 32'd1);
    check("t5_active", {31'd0, active}, 32'd0);
    tick();
    tick();
    check("t5_nlog", wlog.size(), 32'd2);

    // enable dropped mid-scan
    wait_drain(20);
    wlog.delete();
    send_row(8'd7, 16'h0303);
    tick();
    check("t6_first", {16'd0, fifo_write_data}, 32'h0007);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t6_wen_off", {31'd0, fifo_write_en}, 32'd0);
      check("t6_ready_off", {31'd0, row_ready}, 32'd0);
    end
    check("t6_nlog_off", wlog.size(), 32'd1);
    check("t6_count_off", {16'd0, event_count}, 32'd1);
    enable = 1'b1;
    wait_idle("t6_timeout", 20);
    check("t6_nlog", wlog.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wlog.size())
        check("t6_seq", {16'd0, wlog[k]}, {16'd0, exp6[k]});
    end
    check("t6_count", {16'd0, event_count}, 32'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
